mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters.
- M0 is the processor control/datapath: instruction fetch, lw/sw, push/pop.
- M1 is a secondary master, e.g. a program loader or debug port.
- Sequences each access with a fixed wait-state count, returns read data, and pulses a one-cycle acknowledge.
- Sits between the processor/loader and the memory model at top level. The top level performs any tristating onto the memory's inout data bus.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 26, memory word-address width.
- WAIT_CYCLES, 2, extra cycles the memory strobe is held beyond the first (range 0..15).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- M0_REQ  input  1  processor access request; held until M0_ACK.
- M0_WE  input  1  1 = write, 0 = read; sampled at grant.
- M0_ADDR  input  ADDR_WIDTH  processor address; sampled at grant.
- M0_WDATA  input  DATA_WIDTH  processor write data; sampled at grant.
- M0_RDATA  output  DATA_WIDTH  processor read data; valid from M0_ACK until next M0 read completes.
- M0_ACK  output  1  one-cycle completion pulse for M0.
- M1_REQ, M1_WE, M1_ADDR, M1_WDATA, M1_RDATA, M1_ACK: same as M0 for the secondary master.
- MEM_READ  output  1  memory read strobe.
- MEM_WRITE  output  1  memory write strobe.
- MEM_ADDR  output  ADDR_WIDTH  registered address to memory.
- MEM_WDATA  output  DATA_WIDTH  registered write data to memory.
- MEM_RDATA  input  DATA_WIDTH  read data from memory.
- GNT  output  2  one-hot current owner (bit0 = M0, bit1 = M1); 00 in IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, DONE.
- Reset (RST = 1 at a rising edge):
  - state IDLE, GNT = 00.
  - MEM_READ = MEM_WRITE = 0; MEM_ADDR = 0, MEM_WDATA = 0.
  - M0_RDATA = M1_RDATA = 0; M0_ACK = M1_ACK = 0.
  - last_grant = M1, so M0 wins the first contention.
  - Reset mid-access aborts immediately; no ACK is issued.
- IDLE:
  - No REQ: stay in IDLE.
  - One REQ: grant that master.
  - Both REQ: grant the master that is not last_grant (round robin).
- On grant:
  - Latch WE, ADDR and WDATA into MEM_* registers; set GNT and last_grant.
  - Load wait counter = WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - MEM_READ = ~WE and MEM_WRITE = WE, registered, stable for the whole state.
  - Counter decrements each cycle.
  - When counter = 0: on a read, capture MEM_RDATA into the owner's RDATA register; go to DONE.
  - ACCESS therefore lasts WAIT_CYCLES + 1 cycles.
- DONE:
  - Strobes = 0; owner's ACK = 1 for exactly this cycle; GNT is held; next state IDLE.
- Latency: REQ seen in IDLE at cycle 0 -> ACCESS in cycles 1..WAIT_CYCLES+1 -> ACK in cycle WAIT_CYCLES+2. With the default, that is cycle 4.
- Throughput: one IDLE turnaround cycle after DONE, so back-to-back accesses repeat every WAIT_CYCLES+3 cycles.
- Handshake rules:
  - A requester deasserts REQ in the cycle after seeing ACK.
  - REQ still high in IDLE is treated as a new request.
  - Input changes after grant are ignored.
  - REQ dropped mid-access: the access still completes and ACK is still pulsed.
- MEM_READ and MEM_WRITE are never both 1; both ACKs are never 1 simultaneously.
- RDATA registers change only on a completed read for their own master; writes leave them unchanged.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRI_EN.
- Defined: M0 always wins contention; last_grant is unused. M1 is served only when M0_REQ = 0 in IDLE.
- Undefined: round robin as specified above.

Test Plan:
- Single read: M0_REQ = 1, WE = 0, ADDR = 0x0000010, memory returns 0xDEADBEEF.
  -> MEM_READ = 1 in cycles 1-3; M0_ACK in cycle 4; M0_RDATA = 0xDEADBEEF; GNT = 01 in cycles 1-4.
- Single write: M1_REQ = 1, WE = 1, ADDR = 0x03FFFFF, WDATA = 0x12345678.
  -> MEM_WRITE = 1 for 3 cycles with MEM_ADDR/MEM_WDATA = those values; M1_ACK in cycle 4; M1_RDATA unchanged.
- Contention after reset: both REQ raised together.
  -> M0 served first; M1 granted in the IDLE cycle after M0_ACK.
  -> Keeping both asserted gives order M0, M1, M0, M1.
  -> With MEM_ARB_FIXED_PRI_EN defined: M0 only, for as long as it keeps requesting.
- Reset mid-access: RST = 1 in cycle 2 of a write.
  -> Next cycle all strobes 0, GNT = 00, no ACK; the following request is served normally.
- WAIT_CYCLES = 0: M0 read.
  -> MEM_READ for 1 cycle; ACK in cycle 2.
- Early REQ drop: M1_REQ deasserted during ACCESS.
  -> Access completes and M1_ACK still pulses once; arbiter then returns to IDLE with GNT = 00.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single wait-stated memory port with round-robin contention handling.
// Define MEM_ARB_FIXED_PRI_EN to give M0 fixed priority over M1.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 26,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  M0_REQ,
  input  logic                  M0_WE,
  input  logic [ADDR_WIDTH-1:0] M0_ADDR,
  input  logic [DATA_WIDTH-1:0] M0_WDATA,
  output logic [DATA_WIDTH-1:0] M0_RDATA,
  output logic                  M0_ACK,
  input  logic                  M1_REQ,
  input  logic                  M1_WE,
  input  logic [ADDR_WIDTH-1:0] M1_ADDR,
  input  logic [DATA_WIDTH-1:0] M1_WDATA,
  output logic [DATA_WIDTH-1:0] M1_RDATA,
  output logic                  M1_ACK,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  output logic [1:0]            GNT
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            ack_q, ack_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [1:0]            pick;
  logic                  pick_we;

`ifdef MEM_ARB_FIXED_PRI_EN
  always_comb begin
    pick = 2'b00;
    if (M0_REQ) begin
      pick = 2'b01;
    end else if (M1_REQ) begin
      pick = 2'b10;
    end
  end
`else
  // last_q = 1 means M1 owned the port most recently, so M0 wins the next tie.
  logic last_q, last_d;

  always_comb begin
    pick = {M1_REQ, M0_REQ};
    if (M0_REQ && M1_REQ) begin
      pick = last_q ? 2'b01 : 2'b10;
    end
  end
`endif

  assign pick_we = pick[1] ? M1_WE : M0_WE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    ack_d       = 2'b00;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifndef MEM_ARB_FIXED_PRI_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        gnt_d = 2'b00;
        if (pick != 2'b00) begin
          gnt_d       = pick;
          mem_read_d  = ~pick_we;
          mem_write_d = pick_we;
          mem_addr_d  = pick[1] ? M1_ADDR : M0_ADDR;
          mem_wdata_d = pick[1] ? M1_WDATA : M0_WDATA;
          cnt_d       = WaitInit;
          state_d     = StAccess;
`ifndef MEM_ARB_FIXED_PRI_EN
          last_d      = pick[1];
`endif
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          ack_d       = gnt_q;
          state_d     = StDone;
          if (mem_read_q) begin
            if (gnt_q[1]) begin
              rdata1_d = MEM_RDATA;
            end else begin
              rdata0_d = MEM_RDATA;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      gnt_q       <= 2'b00;
      ack_q       <= 2'b00;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifndef MEM_ARB_FIXED_PRI_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifndef MEM_ARB_FIXED_PRI_EN
      last_q      <= last_d;
`endif
    end
  end

  assign M0_RDATA  = rdata0_q;
  assign M1_RDATA  = rdata1_q;
  assign M0_ACK    = ack_q[0];
  assign M1_ACK    = ack_q[1];
  assign MEM_READ  = mem_read_q;
  assign MEM_WRITE = mem_write_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign GNT       = gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a slot/phase timing model and a word-level memory model.
module tb_mem_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 26;
  localparam int W = 2;
  localparam int P = W + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req [2];
  logic          we [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ack, m1_ack;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    gnt;

  logic [DW-1:0] tb_mem [16];
  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] model_rdata [2];
  int            model_last;
  int            total = 0;
  int            bad = 0;

  // Second instance with zero wait states.
  logic          w0_req0, w0_we0;
  logic [AW-1:0] w0_addr0;
  logic [DW-1:0] w0_wdata0;
  logic          w0_zero;
  logic [AW-1:0] w0_zero_addr;
  logic [DW-1:0] w0_zero_data;
  logic [DW-1:0] w0_m0_rdata, w0_m1_rdata, w0_mem_wdata;
  logic          w0_m0_ack, w0_m1_ack, w0_mem_read, w0_mem_write;
  logic [AW-1:0] w0_mem_addr;
  logic [1:0]    w0_gnt;
  logic [DW-1:0] w0_mem_rdata;

  assign mem_rdata    = tb_mem[mem_addr[3:0]];
  assign w0_mem_rdata = 32'hCAFEF00D;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .CLK(clk), .RST(rst),
    .M0_REQ(req[0]), .M0_WE(we[0]), .M0_ADDR(addr[0]), .M0_WDATA(wdata[0]),
    .M0_RDATA(m0_rdata), .M0_ACK(m0_ack),
    .M1_REQ(req[1]), .M1_WE(we[1]), .M1_ADDR(addr[1]), .M1_WDATA(wdata[1]),
    .M1_RDATA(m1_rdata), .M1_ACK(m1_ack),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .GNT(gnt)
  );

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut_w0 (
    .CLK(clk), .RST(rst),
    .M0_REQ(w0_req0), .M0_WE(w0_we0), .M0_ADDR(w0_addr0), .M0_WDATA(w0_wdata0),
    .M0_RDATA(w0_m0_rdata), .M0_ACK(w0_m0_ack),
    .M1_REQ(w0_zero), .M1_WE(w0_zero), .M1_ADDR(w0_zero_addr), .M1_WDATA(w0_zero_data),
    .M1_RDATA(w0_m1_rdata), .M1_ACK(w0_m1_ack),
    .MEM_READ(w0_mem_read), .MEM_WRITE(w0_mem_write), .MEM_ADDR(w0_mem_addr),
    .MEM_WDATA(w0_mem_wdata), .MEM_RDATA(w0_mem_rdata), .GNT(w0_gnt)
  );

  // Memory write lands on the coming edge; outputs are sampled 1 time unit after each edge.
  task automatic tick();
    if (mem_write) tb_mem[mem_addr[3:0]] = mem_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last     = 1;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
  endtask

  // One transaction set starting from IDLE; each served access occupies a P-cycle slot.
  task automatic run_txn(input logic [1:0] mask, input logic [1:0] t_we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [1:0] drop);
    int            order [2];
    int            n, slot, ph, o;
    logic [AW-1:0] ta [2];
    logic [DW-1:0] td [2];
    logic [1:0]    exp_gnt;
    logic [5:0]    exp_v, obs_v;
    ta[0] = a0; ta[1] = a1; td[0] = d0; td[1] = d1;
    if (mask == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRI_EN
      order[0] = 0;
`else
      order[0] = (model_last == 0) ? 1 : 0;
`endif
      order[1] = 1 - order[0];
      n = 2;
    end else begin
      order[0] = mask[1] ? 1 : 0;
      order[1] = 0;
      n = 1;
    end
    for (int m = 0; m < 2; m++) begin
      req[m] = mask[m]; we[m] = t_we[m]; addr[m] = ta[m]; wdata[m] = td[m];
    end
    for (int c = 1; c <= n * P; c++) begin
      tick();
      slot = (c - 1) / P;
      ph   = (c - 1) % P;
      o    = order[slot];
      exp_gnt = (o == 1) ? 2'b10 : 2'b01;
      if (ph <= W) exp_v = {exp_gnt, ~t_we[o], t_we[o], 2'b00};
      else if (ph == W + 1) exp_v = {exp_gnt, 2'b00, exp_gnt};
      else exp_v = 6'b0;
      obs_v = {gnt, mem_read, mem_write, m1_ack, m0_ack};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL txn_ctrl cycle %0d slot %0d: {gnt,rd,wr,ack1,ack0} got %b want %b",
                 c, slot, obs_v, exp_v);
      end
      if (ph <= W) begin
        total++;
        if (mem_addr !== ta[o] || (t_we[o] && mem_wdata !== td[o])) begin
          bad++;
          $display("FAIL txn_mem_bus cycle %0d: addr %h data %h want addr %h data %h",
                   c, mem_addr, mem_wdata, ta[o], td[o]);
        end
        if (ph == 0) begin
          if (drop[o]) req[o] = 1'b0;
          addr[o]  = AW'($urandom);
          wdata[o] = $urandom;
          we[o]    = 1'($urandom);
        end
      end
      if (ph == W + 1) begin
        if (t_we[o]) model_mem[ta[o][3:0]] = td[o];
        else model_rdata[o] = model_mem[ta[o][3:0]];
        total++;
        if (m0_rdata !== model_rdata[0] || m1_rdata !== model_rdata[1]) begin
          bad++;
          $display("FAIL txn_rdata cycle %0d: got %h/%h want %h/%h", c, m0_rdata, m1_rdata,
                   model_rdata[0], model_rdata[1]);
        end
        req[o] = 1'b0;
      end
    end
    model_last = order[n-1];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({gnt, mem_read, mem_write, m0_ack, m1_ack, mem_addr, mem_wdata, m0_rdata, m1_rdata}
        !== '0) begin
      bad++;
      $display("FAIL reset_state: gnt %b rd %b wr %b addr %h wdata %h rdata %h/%h", gnt,
               mem_read, mem_write, mem_addr, mem_wdata, m0_rdata, m1_rdata);
    end
    total++;
    if ({w0_gnt, w0_mem_read, w0_m0_ack, w0_m0_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_state_w0: gnt %b rd %b ack %b", w0_gnt, w0_mem_read, w0_m0_ack);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    tb_mem[0]    = 32'hDEADBEEF;
    model_mem[0] = 32'hDEADBEEF;
    run_txn(2'b01, 2'b00, 26'h0000010, 26'h0, 32'h0, 32'h0, 2'b00);
    total++;
    if (m0_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_read_data: got %h want deadbeef", m0_rdata);
    end
  endtask

  task automatic test_single_write();
    run_txn(2'b10, 2'b10, 26'h0, 26'h03FFFFF, 32'h0, 32'h12345678, 2'b00);
    total++;
    if (m1_rdata !== 32'h0 || tb_mem[15] !== 32'h12345678) begin
      bad++;
      $display("FAIL single_write: m1_rdata %h (want 0) mem %h (want 12345678)", m1_rdata,
               tb_mem[15]);
    end
  endtask

  // Both requests held throughout: IDLE re-arbitrates each time.
  task automatic test_contention();
    int exp_order [4];
    int got [$];
    int g;
    do_reset();
`ifdef MEM_ARB_FIXED_PRI_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b1; we[m] = 1'b0; wdata[m] = '0;
    end
    addr[0] = 26'h3;
    addr[1] = 26'h5;
    for (int c = 1; c <= 4 * P; c++) begin
      tick();
      if (m0_ack) got.push_back(0);
      if (m1_ack) got.push_back(1);
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL contention_count: got %0d acks want 4", got.size());
    end
    for (int k = 0; k < 4; k++) begin
      g = (k < got.size()) ? got[k] : -1;
      total++;
      if (g != exp_order[k]) begin
        bad++;
        $display("FAIL contention_order[%0d]: got M%0d want M%0d", k, g, exp_order[k]);
      end
      model_rdata[exp_order[k]] = model_mem[(exp_order[k] == 1) ? 5 : 3];
    end
    total++;
    if (m0_rdata !== model_rdata[0] || m1_rdata !== model_rdata[1]) begin
      bad++;
      $display("FAIL contention_rdata: got %h/%h want %h/%h", m0_rdata, m1_rdata,
               model_rdata[0], model_rdata[1]);
    end
    model_last = exp_order[3];
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    a = AW'($urandom);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = a; wdata[0] = model_mem[a[3:0]];
    req[1] = 1'b0;
    tick();
    tick();
    total++;
    if (mem_write !== 1'b1 || gnt !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid_pre: wr %b gnt %b want 1 01", mem_write, gnt);
    end
    rst = 1'b1;
    req[0] = 1'b0;
    tick();
    rst = 1'b0;
    model_last     = 1;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    total++;
    if ({gnt, mem_read, mem_write, m1_ack, m0_ack, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_mid_abort: gnt %b rd %b wr %b ack %b%b addr %h", gnt, mem_read,
               mem_write, m1_ack, m0_ack, mem_addr);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if ({gnt, m1_ack, m0_ack} !== 4'b0) begin
        bad++;
        $display("FAIL reset_mid_no_ack cycle %0d: gnt %b ack %b%b", c, gnt, m1_ack, m0_ack);
      end
    end
    run_txn(2'b01, 2'b00, AW'($urandom), 26'h0, 32'h0, 32'h0, 2'b00);
  endtask

  task automatic test_wait0();
    logic [5:0]    exp_v, obs_v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom);
    d = $urandom;
    w0_req0 = 1'b1; w0_we0 = 1'b0; w0_addr0 = a; w0_wdata0 = d;
    for (int c = 1; c <= 3; c++) begin
      tick();
      case (c)
        1:       exp_v = 6'b01_10_00;
        2:       exp_v = 6'b01_00_01;
        default: exp_v = 6'b00_00_00;
      endcase
      obs_v = {w0_gnt, w0_mem_read, w0_mem_write, w0_m1_ack, w0_m0_ack};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL wait0_ctrl cycle %0d: got %b want %b", c, obs_v, exp_v);
      end
      if (c == 1) begin
        total++;
        if (w0_mem_addr !== a || w0_mem_wdata !== d) begin
          bad++;
          $display("FAIL wait0_bus: addr %h data %h want %h %h", w0_mem_addr, w0_mem_wdata, a, d);
        end
      end
      if (c == 2) begin
        w0_req0 = 1'b0;
        total++;
        if (w0_m0_rdata !== 32'hCAFEF00D || w0_m1_rdata !== 32'h0) begin
          bad++;
          $display("FAIL wait0_rdata: got %h/%h want cafef00d/0", w0_m0_rdata, w0_m1_rdata);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(2'($urandom_range(1, 3)), 2'($urandom), AW'($urandom), AW'($urandom),
              $urandom, $urandom, 2'($urandom) & 2'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
    end
    w0_req0 = 1'b0; w0_we0 = 1'b0; w0_addr0 = '0; w0_wdata0 = '0;
    w0_zero = 1'b0; w0_zero_addr = '0; w0_zero_data = '0;
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]    = $urandom;
      model_mem[i] = tb_mem[i];
    end
    model_last     = 1;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_reset_mid();
    test_wait0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
